// File: rtl/ibus_arbiter_if.sv
// Bundle that carries the two requester ports and the shared instruction bus.
// slave is the arbiter's view; master is the view of the environment around it.
interface ibus_arbiter_if #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 64
);
   logic [1:0]                 req_read;
   logic [1:0][ADDR_WIDTH-1:0] req_addr;
   logic [1:0]                 req_stall;
   logic [1:0]                 req_flush;
   logic [1:0]                 resp_valid;
   logic [DATA_WIDTH-1:0]      resp_data;
   logic                       m_read;
   logic [ADDR_WIDTH-1:0]      m_address;
   logic                       m_stall;
   logic                       m_valid;
   logic [DATA_WIDTH-1:0]      m_rddata;

   modport slave (
      input  req_read, req_addr, req_flush, m_stall, m_valid, m_rddata,
      output req_stall, resp_valid, resp_data, m_read, m_address
   );

   modport master (
      output req_read, req_addr, req_flush, m_stall, m_valid, m_rddata,
      input  req_stall, resp_valid, resp_data, m_read, m_address
   );
endinterface

// File: rtl/ibus_arbiter.sv
// Round-robin arbiter sharing one pipelined instruction bus between fetch and
// prefetch; an in-order tag FIFO routes each response back to its issuer.
module ibus_arbiter #(
   parameter int unsigned ADDR_WIDTH      = 32,
   parameter int unsigned DATA_WIDTH      = 64,
   parameter int unsigned MAX_OUTSTANDING = 4
) (
   input  logic          clk,
   input  logic          rst,
   ibus_arbiter_if.slave bus,
   output logic          err
);
   localparam int unsigned PTR_W = $clog2(MAX_OUTSTANDING);
   localparam int unsigned CNT_W = PTR_W + 1;

   typedef enum logic {
      REQ_IFU  = 1'b0,
      REQ_PREF = 1'b1
   } req_id_e;

   typedef struct packed {
      req_id_e id;
      logic    squash;
   } tag_t;

   tag_t             tag_q [MAX_OUTSTANDING];
   tag_t             tag_d [MAX_OUTSTANDING];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   req_id_e          last_grant_q, last_grant_d;
   logic             err_q, err_d;

   logic                  full, empty;
   logic [1:0]            eligible;
   req_id_e               grant;
   logic                  grant_valid;
   logic                  accept;
   logic                  pop;
   tag_t                  head;
   logic [ADDR_WIDTH-1:0] addr_mux;
   logic [DATA_WIDTH-1:0] data_mux;

   assign full  = (count_q == CNT_W'(MAX_OUTSTANDING));
   assign empty = (count_q == '0);

   // Full blocks issue even if a pop lands this cycle: keeps m_valid off the m_read path.
   assign eligible = bus.req_read & ~bus.req_flush & {2{~full & ~rst}};

   always_comb begin
      grant       = REQ_IFU;
      grant_valid = |eligible;
      if (eligible == 2'b11) begin
         grant = (last_grant_q == REQ_IFU) ? REQ_PREF : REQ_IFU;
      end else if (eligible[1]) begin
         grant = REQ_PREF;
      end
   end

   assign accept   = grant_valid & ~bus.m_stall;
   assign addr_mux = bus.req_addr[grant];
   assign data_mux = bus.m_rddata;

   assign bus.m_read    = grant_valid;
   assign bus.m_address = addr_mux;
   assign bus.resp_data = data_mux;

   assign bus.req_stall[0] = bus.req_read[0] & ~(accept & (grant == REQ_IFU));
   assign bus.req_stall[1] = bus.req_read[1] & ~(accept & (grant == REQ_PREF));

   assign head = tag_q[rd_ptr_q];
   assign pop  = bus.m_valid & ~empty & ~rst;

   // A flush landing on the popping head squashes it in the same cycle.
   always_comb begin
      bus.resp_valid = '0;
      if (pop && !head.squash && !bus.req_flush[head.id]) begin
         bus.resp_valid[head.id] = 1'b1;
      end
   end

   always_comb begin
      for (int unsigned i = 0; i < MAX_OUTSTANDING; i++) begin
         tag_d[i] = tag_q[i];
         if (bus.req_flush[tag_q[i].id]) begin
            tag_d[i].squash = 1'b1;
         end
      end
      if (accept) begin
         tag_d[wr_ptr_q] = '{id: grant, squash: 1'b0};
      end
      wr_ptr_d     = wr_ptr_q + PTR_W'(accept);
      rd_ptr_d     = rd_ptr_q + PTR_W'(pop);
      count_d      = count_q + CNT_W'(accept) - CNT_W'(pop);
      last_grant_d = accept ? grant : last_grant_q;
      err_d        = err_q | (bus.m_valid & empty);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < MAX_OUTSTANDING; i++) begin
            tag_q[i] <= '0;
         end
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         last_grant_q <= REQ_PREF;
         err_q        <= 1'b0;
      end else begin
         for (int unsigned i = 0; i < MAX_OUTSTANDING; i++) begin
            tag_q[i] <= tag_d[i];
         end
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         last_grant_q <= last_grant_d;
         err_q        <= err_d;
      end
   end

   assign err = err_q;
endmodule

// File: tb/tb_ibus_arbiter.sv
// Directed bench for ibus_arbiter: inputs change on the falling edge and the
// combinational outputs are sampled 1 time unit later.
module tb_ibus_arbiter;
   logic clk;
   logic rst;
   logic err;
   int   n_cmp;
   int   n_bad;

   ibus_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(64)) bus ();

   ibus_arbiter #(
      .ADDR_WIDTH(32),
      .DATA_WIDTH(64),
      .MAX_OUTSTANDING(4)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus),
      .err(err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic drv(input logic [1:0] rd, input logic [1:0] fl, input logic st,
                      input logic mv, input logic [63:0] d);
      bus.req_read  = rd;
      bus.req_flush = fl;
      bus.m_stall   = st;
      bus.m_valid   = mv;
      bus.m_rddata  = d;
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      drv(2'b00, 2'b00, 1'b0, 1'b0, 64'h0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      n_cmp = 0;
      n_bad = 0;
      bus.req_addr = '0;

      // Outputs while reset is held, with both requesters asking
      rst = 1'b1;
      drv(2'b11, 2'b00, 1'b0, 1'b0, 64'h0);
      check("rst_m_read", 64'(bus.m_read), 64'h0);
      check("rst_req_stall", 64'(bus.req_stall), 64'h3);
      check("rst_resp_valid", 64'(bus.resp_valid), 64'h0);
      @(negedge clk);
      @(negedge clk);
      check("rst_err", 64'(err), 64'h0);
      rst = 1'b0;

      // Single requester, response two cycles later
      bus.req_addr[0] = 32'h100;
      drv(2'b01, 2'b00, 1'b0, 1'b0, 64'h0);
      check("t1_m_read", 64'(bus.m_read), 64'h1);
      check("t1_m_address", 64'(bus.m_address), 64'h100);
      check("t1_req_stall", 64'(bus.req_stall), 64'h0);
      @(negedge clk);
      drv(2'b00, 2'b00, 1'b0, 1'b0, 64'h0);
      @(negedge clk);
      drv(2'b00, 2'b00, 1'b0, 1'b1, 64'hAB);
      check("t1_resp_valid", 64'(bus.resp_valid), 64'h1);
      check("t1_resp_data", bus.resp_data, 64'hAB);
      @(negedge clk);
      drv(2'b00, 2'b00, 1'b0, 1'b0, 64'h0);
      check("t1_idle_resp_valid", 64'(bus.resp_valid), 64'h0);

      // Both requesting: alternating grants until the FIFO fills
      do_reset();
      bus.req_addr[0] = 32'h200;
      bus.req_addr[1] = 32'h300;
      for (int k = 0; k < 4; k++) begin
         drv(2'b11, 2'b00, 1'b0, 1'b0, 64'h0);
         check("t2_m_address", 64'(bus.m_address), (k % 2 == 1) ? 64'h300 : 64'h200);
         check("t2_req_stall", 64'(bus.req_stall), (k % 2 == 1) ? 64'h1 : 64'h2);
         @(negedge clk);
      end
      drv(2'b11, 2'b00, 1'b0, 1'b0, 64'h0);
      check("t2_full_m_read", 64'(bus.m_read), 64'h0);
      check("t2_full_req_stall", 64'(bus.req_stall), 64'h3);
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
         drv(2'b00, 2'b00, 1'b0, 1'b1, 64'h1000 + 64'(k));
         check("t2_resp_valid", 64'(bus.resp_valid), (k % 2 == 1) ? 64'h2 : 64'h1);
         check("t2_resp_data", bus.resp_data, 64'h1000 + 64'(k));
         @(negedge clk);
      end

      // Bus stall: grant holds, last grant was requester 1 so 0 wins after
      for (int k = 0; k < 3; k++) begin
         drv(2'b11, 2'b00, 1'b1, 1'b0, 64'h0);
         check("t3_stall_m_read", 64'(bus.m_read), 64'h1);
         check("t3_stall_req_stall", 64'(bus.req_stall), 64'h3);
         @(negedge clk);
      end
      drv(2'b11, 2'b00, 1'b0, 1'b0, 64'h0);
      check("t3_accept_req_stall", 64'(bus.req_stall), 64'h2);
      check("t3_accept_m_address", 64'(bus.m_address), 64'h200);
      @(negedge clk);
      drv(2'b00, 2'b00, 1'b0, 1'b1, 64'h55);
      check("t3_resp_valid", 64'(bus.resp_valid), 64'h1);
      @(negedge clk);

      // Four outstanding reads block the fifth until one pops
      do_reset();
      bus.req_addr[0] = 32'h400;
      for (int k = 0; k < 4; k++) begin
         drv(2'b01, 2'b00, 1'b0, 1'b0, 64'h0);
         check("t4_fill_req_stall", 64'(bus.req_stall), 64'h0);
         @(negedge clk);
      end
      drv(2'b01, 2'b00, 1'b0, 1'b1, 64'h66);
      check("t4_full_m_read", 64'(bus.m_read), 64'h0);
      check("t4_full_req_stall", 64'(bus.req_stall), 64'h1);
      check("t4_pop_resp_valid", 64'(bus.resp_valid), 64'h1);
      @(negedge clk);
      drv(2'b01, 2'b00, 1'b0, 1'b0, 64'h0);
      check("t4_reaccept_m_read", 64'(bus.m_read), 64'h1);
      check("t4_reaccept_req_stall", 64'(bus.req_stall), 64'h0);
      @(negedge clk);

      // Outstanding 0,1,0 then flush requester 0
      do_reset();
      bus.req_addr[0] = 32'h500;
      bus.req_addr[1] = 32'h600;
      drv(2'b01, 2'b00, 1'b0, 1'b0, 64'h0);
      @(negedge clk);
      drv(2'b10, 2'b00, 1'b0, 1'b0, 64'h0);
      @(negedge clk);
      drv(2'b01, 2'b00, 1'b0, 1'b0, 64'h0);
      @(negedge clk);
      drv(2'b00, 2'b01, 1'b0, 1'b0, 64'h0);
      @(negedge clk);
      drv(2'b00, 2'b00, 1'b0, 1'b1, 64'h71);
      check("t5_resp0", 64'(bus.resp_valid), 64'h0);
      @(negedge clk);
      drv(2'b00, 2'b00, 1'b0, 1'b1, 64'h72);
      check("t5_resp1", 64'(bus.resp_valid), 64'h2);
      check("t5_resp1_data", bus.resp_data, 64'h72);
      @(negedge clk);
      drv(2'b00, 2'b00, 1'b0, 1'b1, 64'h73);
      check("t5_resp2", 64'(bus.resp_valid), 64'h0);
      @(negedge clk);
      drv(2'b00, 2'b00, 1'b0, 1'b0, 64'h0);
      check("t5_err", 64'(err), 64'h0);

      // Flush in the same cycle the head pops, requester still asking
      drv(2'b01, 2'b00, 1'b0, 1'b0, 64'h0);
      @(negedge clk);
      drv(2'b01, 2'b01, 1'b0, 1'b1, 64'h81);
      check("t5b_req_stall", 64'(bus.req_stall), 64'h1);
      check("t5b_m_read", 64'(bus.m_read), 64'h0);
      check("t5b_resp_valid", 64'(bus.resp_valid), 64'h0);
      @(negedge clk);
      drv(2'b00, 2'b00, 1'b0, 1'b0, 64'h0);
      check("t5b_err", 64'(err), 64'h0);

      // Response with nothing outstanding sets a sticky error
      do_reset();
      drv(2'b00, 2'b00, 1'b0, 1'b1, 64'h99);
      check("t6_resp_valid", 64'(bus.resp_valid), 64'h0);
      @(negedge clk);
      drv(2'b00, 2'b00, 1'b0, 1'b0, 64'h0);
      check("t6_err_set", 64'(err), 64'h1);
      @(negedge clk);
      @(negedge clk);
      check("t6_err_sticky", 64'(err), 64'h1);
      rst = 1'b1;
      @(negedge clk);
      check("t6_err_cleared", 64'(err), 64'h0);
      rst = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/ibus_arbiter.md
Name: ibus_arbiter

Overview:
- Shares one pipelined instruction bus between two fetch requesters: requester 0 is the instruction fetch unit, requester 1 is the prefetch/refill path.
- Round-robin arbitration selects which requester drives the bus each cycle.
- A small in-order tag FIFO records the owner of every outstanding read, so each bus response is routed back to the requester that issued it.
- A per-requester flush squashes that requester's in-flight responses (used on pc redirect / exception).

Parameters:
- ADDR_WIDTH, 32, byte address width.
- DATA_WIDTH, 64, bus read data width (FETCH_NUM x 32).
- MAX_OUTSTANDING, 4, tag FIFO depth; power of two, at least 2.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- req_read  in  2  per-requester read request, level, held until accepted.
- req_addr  in  2xADDR_WIDTH  per-requester address; must be stable while req_read is high.
- req_stall  out  2  per-requester "not accepted this cycle".
- req_flush  in  2  squash all of this requester's outstanding reads.
- resp_valid  out  2  per-requester response strobe.
- resp_data  out  DATA_WIDTH  response data, broadcast to both requesters.
- m_read  out  1  bus read request.
- m_address  out  ADDR_WIDTH  bus address.
- m_stall  in  1  bus cannot accept a request this cycle.
- m_valid  in  1  bus returns one response, in request order.
- m_rddata  in  DATA_WIDTH  bus response data.
- err  out  1  sticky protocol error: response received with no outstanding read.

Behaviour:
- Reset: FIFO empty (count=0, pointers=0), last_grant=1 so requester 0 wins the first tie, err=0.
- Reset value of every output: m_read=0, resp_valid=0, req_stall=2'b11 for any asserted req_read, err=0.
- Reset mid-operation discards all outstanding tags. Responses arriving after reset with an empty FIFO set err.
- Eligibility (combinational): requester i is eligible when req_read[i]=1, req_flush[i]=0, and FIFO not full.
  - FIFO full blocks both requesters, even when m_valid pops in the same cycle. This avoids a combinational m_valid -> m_read path.
- Grant:
  - One eligible requester: it is granted.
  - Both eligible: the requester != last_grant is granted.
  - m_read=1 iff a grant exists; m_address = req_addr of the granted requester; zero latency, combinational.
- Accept: the request is accepted when m_read=1 and m_stall=0.
  - On accept: push tag {id=grant, squash=0}; last_grant<=grant.
- req_stall[i] = req_read[i] & ~(accepted & grant==i).
  - A flushed requester sees req_stall=1 during its flush cycle.
- Response: on m_valid with FIFO non-empty, pop the head.
  - resp_valid[head.id] = ~head.squash, same cycle, combinational.
  - resp_data = m_rddata at all times.
  - m_valid with an empty FIFO: no resp_valid, err<=1.
- Flush: req_flush[i] sets squash=1 on every valid FIFO entry with id==i at the clock edge.
  - If the head is popped in the same cycle, the squash applies to that head's response: resp_valid is suppressed combinationally when head.id==i and req_flush[i]=1.
  - A flush does not cancel entries belonging to the other requester.
- Simultaneous push and pop: count unchanged; both pointers advance, wrapping modulo MAX_OUTSTANDING.
- Count width: $clog2(MAX_OUTSTANDING)+1. full = (count==MAX_OUTSTANDING), empty = (count==0).
- last_grant updates only on accept; it does not change on m_stall cycles.

Test Plan:
- Single requester: req_read[0]=1 with addr 0x100, m_stall=0, response 2 cycles later (data 0xAB) -> m_address=0x100 in cycle 0, req_stall[0]=0, resp_valid=2'b01 with resp_data=0xAB in cycle 2.
- Both requesting continuously with m_stall=0 -> grants alternate 0,1,0,1. Responses return in order; resp_valid alternates 01,10,01,10.
- m_stall=1 for 3 cycles while both request -> m_read stays 1 and req_stall=2'b11. last_grant holds, so the first accept after m_stall falls is requester 0.
- Issue 4 reads from requester 0 with no responses -> 5th cycle m_read=0, req_stall[0]=1. Pop one response -> next cycle the request is accepted again.
- Outstanding order 0,1,0: assert req_flush[0] for one cycle, then return 3 responses -> only the second produces resp_valid=2'b10; the other two give resp_valid=0 and err stays 0.
- After reset, m_valid=1 with no requests -> resp_valid=0, err=1 and stays 1 until the next rst.
